stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Central sequencer for the stopwatch. It consumes the single-cycle start/stop/split/reset pulses from the button front-end and a 100 Hz enable tick. It owns the mm:ss.cc elapsed-time counter and the split (lap) freeze register, and it drives the time value shown by the display path.

Parameters:
MAX_MIN, 59, highest minute value before wrap to 00:00.00
CS_PER_SEC, 100, centisecond counts per second (bench may lower it for fast sims)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick_cs  input  1  one-clk pulse per centisecond, synchronous to clk
start  input  1  one-clk start pulse
stop  input  1  one-clk stop pulse
split  input  1  one-clk split/lap pulse
reset  input  1  one-clk clear pulse (user button, not rst_n)
disp_min  output  6  displayed minutes, binary 0..MAX_MIN
disp_sec  output  6  displayed seconds, binary 0..59
disp_cs  output  7  displayed centiseconds, binary 0..CS_PER_SEC-1
state  output  2  00 IDLE, 01 RUN, 10 SPLIT, 11 STOPPED
running  output  1  1 in RUN or SPLIT
frozen  output  1  1 in SPLIT (display shows latched split)
overflow  output  1  sticky, set on wrap past MAX_MIN:59.(CS_PER_SEC-1)

Behaviour:
- One clock: clk. rst_n is asynchronous and active-low. All state, counters, split register and outputs are flops cleared by rst_n.
- Reset values (rst_n low): state=IDLE, count=00:00.00, split reg=0, all disp_* = 0, running=0, frozen=0, overflow=0.
- Internal count: cascaded cs/sec/min counters.
  - cs wraps at CS_PER_SEC-1 and carries into sec.
  - sec wraps at 59 and carries into min.
  - min wraps at MAX_MIN to 0. That wrap sets overflow.
- Count increments by one cs on a cycle with tick_cs=1 whose current state is RUN or SPLIT. The decision uses the registered state, not the next state.
- Pulse priority when pulses coincide: reset > stop > start > split. Only the highest-priority valid pulse acts; the rest are dropped.
- Transitions (evaluated each clk; a pulse that is not valid in the current state is ignored):
  - IDLE: start -> RUN.
  - RUN: stop -> STOPPED. split -> SPLIT; the split register loads the current count (pre-increment value of this cycle).
  - SPLIT: stop -> STOPPED (display returns live). split -> RUN (release freeze). Counting continues throughout.
  - STOPPED: start -> RUN (resume, count kept). split ignored.
  - Any state: reset -> IDLE. Count, split register and overflow are cleared next cycle.
- Tick and pulse in the same cycle:
  - Tick with stop in RUN/SPLIT: the tick is counted.
  - Tick with start in IDLE/STOPPED: the tick is not counted.
  - Tick with reset: the count clears to 0 and the tick is lost.
- Display outputs are registered, one cycle after count/state update:
  - SPLIT shows the split register.
  - All other states show the live count.
  - IDLE therefore shows 00:00.00.
- running, frozen and state are registered with the state flop. Zero extra latency: they change on the clk edge that takes the pulse.
- overflow stays 1 until the reset pulse or rst_n. The count continues from 00:00.00 after wrap.
- rst_n asserted mid-run: immediate asynchronous clear. After release, the block sits in IDLE until a start pulse.

Test Plan:
- Reset pulse: rst_n low -> all outputs 0, state=00. Release, start pulse, 150 ticks -> state=01, running=1, disp=00:01.50 one cycle after the last tick.
- Split freeze: in RUN at 00:02.37, split pulse. Then 100 ticks -> disp_* hold 00:02.37 and frozen=1. Second split -> disp=00:03.37, state=01.
- Stop/resume: stop at 00:05.00, then 50 ticks -> disp stays 00:05.00, state=11. Start, 1 tick -> 00:05.01.
- Simultaneous events:
  - start+stop same cycle in RUN -> STOPPED.
  - reset+start in STOPPED -> IDLE, disp 00:00.00.
  - tick+stop same cycle -> tick counted.
- Wrap: MAX_MIN=1, CS_PER_SEC=4, run past 01:59.03 -> disp 00:00.00, overflow=1. overflow remains 1 until a reset pulse clears it.
- Async reset mid-operation: rst_n low for a partial cycle while in SPLIT -> outputs clear without a clk edge. After release, state=IDLE and ticks are ignored.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: owns the mm:ss.cc counter, split register and display registers.
// State flags change on the pulse edge; display lags count/state by one cycle; no backpressure.
module stopwatch_ctrl #(
  parameter int MAX_MIN    = 59,
  parameter int CS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_cs,
  input  logic       start,
  input  logic       stop,
  input  logic       split,
  input  logic       reset,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [6:0] disp_cs,
  output logic [1:0] state,
  output logic       running,
  output logic       frozen,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_SPLIT   = 2'b10,
    S_STOPPED = 2'b11
  } state_t;

  localparam logic [6:0] CS_LAST  = 7'(CS_PER_SEC - 1);
  localparam logic [5:0] SEC_LAST = 6'd59;
  localparam logic [5:0] MIN_LAST = 6'(MAX_MIN);

  state_t     state_q, state_d;
  logic       load_split, clear_all;
  logic       running_q, frozen_q, overflow_q;
  logic [6:0] cs_q, split_cs_q;
  logic [5:0] sec_q, min_q, split_sec_q, split_min_q;
  logic       cnt_en, cs_last, sec_last, min_last;

  // Pulses not legal in the current state are dropped before priority is applied.
  always_comb begin
    state_d    = state_q;
    load_split = 1'b0;
    clear_all  = 1'b0;
    if (reset) begin
      state_d   = S_IDLE;
      clear_all = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_STOPPED;
          end else if (split) begin
            state_d    = S_SPLIT;
            load_split = 1'b1;
          end
        end
        S_SPLIT: begin
          if (stop)       state_d = S_STOPPED;
          else if (split) state_d = S_RUN;
        end
        S_STOPPED: begin
          if (start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN) || (state_d == S_SPLIT);
      frozen_q  <= (state_d == S_SPLIT);
    end
  end

  // Counting keys off the registered state, so a start tick is lost and a stop tick counts.
  assign cnt_en   = tick_cs && ((state_q == S_RUN) || (state_q == S_SPLIT));
  assign cs_last  = (cs_q == CS_LAST);
  assign sec_last = (sec_q == SEC_LAST);
  assign min_last = (min_q == MIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q        <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      split_cs_q  <= '0;
      split_sec_q <= '0;
      split_min_q <= '0;
      overflow_q  <= 1'b0;
    end else if (clear_all) begin
      cs_q        <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      split_cs_q  <= '0;
      split_sec_q <= '0;
      split_min_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (cnt_en) begin
        if (cs_last) begin
          cs_q <= '0;
          if (sec_last) begin
            sec_q <= '0;
            if (min_last) begin
              min_q      <= '0;
              overflow_q <= 1'b1;
            end else begin
              min_q <= min_q + 6'd1;
            end
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end else begin
          cs_q <= cs_q + 7'd1;
        end
      end
      if (load_split) begin
        split_cs_q  <= cs_q;
        split_sec_q <= sec_q;
        split_min_q <= min_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_min <= '0;
      disp_sec <= '0;
      disp_cs  <= '0;
    end else if (state_q == S_SPLIT) begin
      disp_min <= split_min_q;
      disp_sec <= split_sec_q;
      disp_cs  <= split_cs_q;
    end else begin
      disp_min <= min_q;
      disp_sec <= sec_q;
      disp_cs  <= cs_q;
    end
  end

  assign state    = state_q;
  assign running  = running_q;
  assign frozen   = frozen_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: one default instance plus a small-parameter instance for wrap.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_cs = 1'b0, start = 1'b0, stop = 1'b0, split = 1'b0, reset = 1'b0;

  logic [5:0] a_min, a_sec, w_min, w_sec;
  logic [6:0] a_cs, w_cs;
  logic [1:0] a_state, w_state;
  logic       a_run, a_frz, a_ovf, w_run, w_frz, w_ovf;

  always #5 clk = ~clk;

  stopwatch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .tick_cs(tick_cs), .start(start), .stop(stop),
    .split(split), .reset(reset), .disp_min(a_min), .disp_sec(a_sec), .disp_cs(a_cs),
    .state(a_state), .running(a_run), .frozen(a_frz), .overflow(a_ovf)
  );

  stopwatch_ctrl #(.MAX_MIN(1), .CS_PER_SEC(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .tick_cs(tick_cs), .start(start), .stop(stop),
    .split(split), .reset(reset), .disp_min(w_min), .disp_sec(w_sec), .disp_cs(w_cs),
    .state(w_state), .running(w_run), .frozen(w_frz), .overflow(w_ovf)
  );

  typedef struct {
    string      name;
    bit         which;
    logic [1:0] st;
    logic       run;
    logic       frz;
    logic       ovf;
    int         mn;
    int         sc;
    int         cs;
  } obs_t;

  // inputs are {tick, start, stop, split, reset}; expectations are sampled after the edge
  typedef struct {
    logic [4:0] in;
    logic [1:0] st;
    logic       run;
    logic       frz;
    int         cs;
  } vec_t;

  obs_t sb[$];
  vec_t tbl[24];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string nm, input bit w, input logic [1:0] st, input logic run,
                      input logic frz, input logic ovf, input int mn, input int sc, input int cs);
    obs_t e;
    e.name = nm; e.which = w; e.st = st; e.run = run; e.frz = frz; e.ovf = ovf;
    e.mn = mn; e.sc = sc; e.cs = cs;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    obs_t e;
    logic [1:0] st;
    logic run, frz, ovf;
    int mn, sc, cs;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got no expectation, need one");
      return;
    end
    e = sb.pop_front();
    if (e.which) begin
      st = w_state; run = w_run; frz = w_frz; ovf = w_ovf;
      mn = int'(w_min); sc = int'(w_sec); cs = int'(w_cs);
    end else begin
      st = a_state; run = a_run; frz = a_frz; ovf = a_ovf;
      mn = int'(a_min); sc = int'(a_sec); cs = int'(a_cs);
    end
    if (st !== e.st || run !== e.run || frz !== e.frz || ovf !== e.ovf ||
        mn != e.mn || sc != e.sc || cs != e.cs) begin
      fails++;
      $display("FAIL %s: got st=%b run=%b frz=%b ovf=%b %0d:%0d.%0d, need st=%b run=%b frz=%b ovf=%b %0d:%0d.%0d",
               e.name, st, run, frz, ovf, mn, sc, cs,
               e.st, e.run, e.frz, e.ovf, e.mn, e.sc, e.cs);
    end
  endtask

  task automatic step(input logic [4:0] in);
    {tick_cs, start, stop, split, reset} = in;
    @(negedge clk);
    {tick_cs, start, stop, split, reset} = 5'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(5'b10000);
  endtask

  initial begin
    tbl[0]  = '{5'b00000, 2'b00, 1'b0, 1'b0, 0};
    tbl[1]  = '{5'b10000, 2'b00, 1'b0, 1'b0, 0};
    tbl[2]  = '{5'b11000, 2'b01, 1'b1, 1'b0, 0};
    tbl[3]  = '{5'b10000, 2'b01, 1'b1, 1'b0, 0};
    tbl[4]  = '{5'b10000, 2'b01, 1'b1, 1'b0, 1};
    tbl[5]  = '{5'b00000, 2'b01, 1'b1, 1'b0, 2};
    tbl[6]  = '{5'b10010, 2'b10, 1'b1, 1'b1, 2};
    tbl[7]  = '{5'b10000, 2'b10, 1'b1, 1'b1, 2};
    tbl[8]  = '{5'b10000, 2'b10, 1'b1, 1'b1, 2};
    tbl[9]  = '{5'b00010, 2'b01, 1'b1, 1'b0, 2};
    tbl[10] = '{5'b00000, 2'b01, 1'b1, 1'b0, 5};
    tbl[11] = '{5'b10100, 2'b11, 1'b0, 1'b0, 5};
    tbl[12] = '{5'b10000, 2'b11, 1'b0, 1'b0, 6};
    tbl[13] = '{5'b00010, 2'b11, 1'b0, 1'b0, 6};
    tbl[14] = '{5'b01000, 2'b01, 1'b1, 1'b0, 6};
    tbl[15] = '{5'b01100, 2'b11, 1'b0, 1'b0, 6};
    tbl[16] = '{5'b11001, 2'b00, 1'b0, 1'b0, 6};
    tbl[17] = '{5'b01000, 2'b01, 1'b1, 1'b0, 0};
    tbl[18] = '{5'b10000, 2'b01, 1'b1, 1'b0, 0};
    tbl[19] = '{5'b00010, 2'b10, 1'b1, 1'b1, 1};
    tbl[20] = '{5'b10110, 2'b11, 1'b0, 1'b0, 1};
    tbl[21] = '{5'b00000, 2'b11, 1'b0, 1'b0, 2};
    tbl[22] = '{5'b00001, 2'b00, 1'b0, 1'b0, 2};
    tbl[23] = '{5'b00000, 2'b00, 1'b0, 1'b0, 0};

    // power-on reset, then 150 ticks from a start
    #1 rst_n = 1'b0;
    #1;
    push("por_clear", 0, 2'b00, 0, 0, 0, 0, 0, 0); pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    step(5'b01000);
    ticks(150);
    push("run_150", 0, 2'b01, 1, 0, 0, 0, 1, 50);
    step(5'b00000); pop_check();

    // split freeze at 00:02.37
    ticks(87);
    step(5'b00010);
    ticks(100);
    push("split_hold", 0, 2'b10, 1, 1, 0, 0, 2, 37);
    pop_check();
    push("split_release", 0, 2'b01, 1, 0, 0, 0, 2, 37);
    step(5'b00010); pop_check();
    push("split_live", 0, 2'b01, 1, 0, 0, 0, 3, 37);
    step(5'b00000); pop_check();

    // stop at 00:05.00, ticks ignored, resume
    ticks(163);
    step(5'b00100);
    ticks(50);
    push("stop_hold", 0, 2'b11, 0, 0, 0, 0, 5, 0);
    pop_check();
    step(5'b01000);
    step(5'b10000);
    push("resume", 0, 2'b01, 1, 0, 0, 0, 5, 1);
    step(5'b00000); pop_check();

    // async reset inside SPLIT, released before the next rising edge
    step(5'b00010);
    ticks(3);
    #1 rst_n = 1'b0;
    #1;
    push("async_clear", 0, 2'b00, 0, 0, 0, 0, 0, 0); pop_check();
    #1 rst_n = 1'b1;
    ticks(5);
    push("idle_after_rst", 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(5'b00000); pop_check();

    // per-cycle vectors for coincident pulses and ticks
    for (int i = 0; i < 24; i++) begin
      push($sformatf("vec%0d", i), 0, tbl[i].st, tbl[i].run, tbl[i].frz, 1'b0, 0, 0, tbl[i].cs);
      step(tbl[i].in);
      pop_check();
    end

    // wrap on the MAX_MIN=1, CS_PER_SEC=4 instance: last value 01:59.03 is count 479
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(5'b01000);
    ticks(479);
    push("pre_wrap", 1, 2'b01, 1, 0, 0, 1, 59, 3);
    step(5'b00000); pop_check();
    push("wrap_edge", 1, 2'b01, 1, 0, 1, 1, 59, 3);
    step(5'b10000); pop_check();
    push("wrap_disp", 1, 2'b01, 1, 0, 1, 0, 0, 0);
    step(5'b00000); pop_check();
    ticks(6);
    push("ovf_sticky", 1, 2'b01, 1, 0, 1, 0, 1, 2);
    step(5'b00000); pop_check();
    push("ovf_clear", 1, 2'b00, 0, 0, 0, 0, 1, 2);
    step(5'b00001); pop_check();
    push("idle_zero", 1, 2'b00, 0, 0, 0, 0, 0, 0);
    step(5'b00000); pop_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
